// File: rtl/ahb_spi_slave.sv
// AHB-Lite slave acting as an SPI mode-0 target: 8-bit full-duplex frames,
// RX FIFO, single TX holding byte, registered level interrupt.
module ahb_spi_slave #(
  parameter int unsigned RX_DEPTH  = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_N,
  output logic        MISO,
  output logic        MISO_OE,
  output logic        IRQ
);

  localparam int unsigned PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  state_t state, state_nxt;

  logic [1:0]    addr_q;
  logic          wr_q, rd_q;
  logic          sclk_s1, sclk_s2, sclk_h, mosi_s1, mosi_s2, ss_s1, ss_s2, ss_h;
  logic [7:0]    tx_hold, shift_tx, shift_rx, rx_next;
  logic          tx_valid;
  logic [2:0]    bitcnt;
  logic          ovr, undr, frmerr, irq_q;
  logic [2:0]    ctrl;
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [4:0]    rx_cnt;
  logic          active, sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic          rx_ne, rx_full, push_req, push, pop, tx_load;
  logic          wr_status, wr_tx, wr_ctrl;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

  assign active    = (state == ST_ACTIVE);
  assign sclk_rise = sclk_s2 & ~sclk_h;
  assign sclk_fall = ~sclk_s2 & sclk_h;
  assign ss_fall   = ~ss_s2 & ss_h;
  assign ss_rise   = ss_s2 & ~ss_h;

  assign rx_ne    = (rx_cnt != 5'd0);
  assign rx_full  = (rx_cnt == 5'(RX_DEPTH));
  assign rx_next  = LSB_FIRST ? {mosi_s2, shift_rx[7:1]} : {shift_rx[6:0], mosi_s2};
  assign push_req = active & sclk_rise & (bitcnt == 3'd7);
  assign pop      = rd_q & (addr_q == 2'd2) & rx_ne;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign push     = push_req & (~rx_full | pop);
  assign tx_load  = ss_fall | (active & sclk_fall & (bitcnt == 3'd0));

  assign wr_status = wr_q & (addr_q == 2'd0);
  assign wr_tx     = wr_q & (addr_q == 2'd1);
  assign wr_ctrl   = wr_q & (addr_q == 2'd3);

  always_comb begin
    state_nxt = state;
    if (ss_fall)      state_nxt = ST_ACTIVE;
    else if (ss_rise) state_nxt = ST_IDLE;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_h   <= 1'b0;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
      ss_s1    <= 1'b0;
      ss_s2    <= 1'b0;
      ss_h     <= 1'b0;
      tx_hold  <= '0;
      tx_valid <= 1'b0;
      shift_tx <= '0;
      shift_rx <= '0;
      bitcnt   <= '0;
      ovr      <= 1'b0;
      undr     <= 1'b0;
      frmerr   <= 1'b0;
      ctrl     <= '0;
      irq_q    <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      rx_cnt   <= '0;
      for (int unsigned i = 0; i < RX_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (HREADY) begin
        addr_q <= HADDR[3:2];
        wr_q   <= HSEL & HWRITE & HTRANS[1];
        rd_q   <= HSEL & ~HWRITE & HTRANS[1];
      end

      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_h  <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      ss_s1   <= SS_N;
      ss_s2   <= ss_s1;
      ss_h    <= ss_s2;

      if (wr_status) begin
        if (HWDATA[3]) ovr    <= 1'b0;
        if (HWDATA[4]) undr   <= 1'b0;
        if (HWDATA[5]) frmerr <= 1'b0;
      end
      if (wr_ctrl) ctrl <= HWDATA[2:0];

      // A load coincident with a TXDATA write takes the old byte; the write lands afterwards
      if (tx_load) begin
        shift_tx <= tx_valid ? tx_hold : 8'h00;
        if (tx_valid) tx_valid <= 1'b0;
        else          undr     <= 1'b1;
      end else if (active & sclk_fall) begin
        shift_tx <= LSB_FIRST ? {1'b0, shift_tx[7:1]} : {shift_tx[6:0], 1'b0};
      end
      if (wr_tx) begin
        tx_hold  <= HWDATA[7:0];
        tx_valid <= 1'b1;
      end

      if (active & sclk_rise) begin
        shift_rx <= rx_next;
        bitcnt   <= bitcnt + 3'd1;
      end
      if (ss_fall) bitcnt <= '0;
      if (ss_rise) begin
        bitcnt <= '0;
        if (bitcnt != 3'd0) frmerr <= 1'b1;
      end

      if (push) begin
        fifo_mem[wptr] <= rx_next;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push_req & ~push) ovr <= 1'b1;
      case ({push, pop})
        2'b10:   rx_cnt <= rx_cnt + 5'd1;
        2'b01:   rx_cnt <= rx_cnt - 5'd1;
        default: rx_cnt <= rx_cnt;
      endcase

      irq_q <= (ctrl[0] & rx_ne) | (ctrl[1] & ~tx_valid) | (ctrl[2] & (ovr | undr | frmerr));
    end
  end

  always_comb begin
    HRDATA = '0;
    if (rd_q) begin
      case (addr_q)
        2'd0: HRDATA = {20'd0, rx_cnt[3:0], 1'b0, active, frmerr, undr, ovr,
                        rx_full, rx_ne, ~tx_valid};
        2'd1: HRDATA = {24'd0, tx_hold};
        2'd2: HRDATA = rx_ne ? {24'd0, fifo_mem[rptr]} : '0;
        default: HRDATA = {29'd0, ctrl};
      endcase
    end
  end

  assign MISO    = active & (LSB_FIRST ? shift_tx[0] : shift_tx[7]);
  assign MISO_OE = active;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_ahb_spi_slave.sv
// Directed bench for ahb_spi_slave: register-access table plus hand-written
// SPI frame sequences (overflow, framing error, push/pop collision, mid-frame reset).
module tb_ahb_spi_slave;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HREADY, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        SCLK, MOSI, SS_N, MISO, MISO_OE, IRQ;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_spi_slave #(.RX_DEPTH(4), .LSB_FIRST(1'b0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .SCLK(SCLK), .MOSI(MOSI), .SS_N(SS_N),
    .MISO(MISO), .MISO_OE(MISO_OE), .IRQ(IRQ)
  );

  typedef struct {
    logic [3:0]  addr;
    bit          wr;
    logic [31:0] data;   // write data, or expected read data
  } reg_vec_t;

  reg_vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b1;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = 1'b0;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    check(name, d, exp);
  endtask

  // Master side: sends the top n bits of mo MSB first, returns bits seen on MISO
  task automatic spi_bits(input int unsigned n, input logic [7:0] mo, output logic [7:0] mi);
    logic [7:0] m;
    m  = mo;
    mi = '0;
    for (int unsigned i = 0; i < n; i++) begin
      MOSI = m[7];
      m    = {m[6:0], 1'b0};
      repeat (8) @(negedge HCLK);
      mi   = {mi[6:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(negedge HCLK);
      SCLK = 1'b0;
    end
  endtask

  task automatic frame_start;
    SS_N = 1'b0;
    repeat (8) @(negedge HCLK);
  endtask

  task automatic frame_end;
    repeat (8) @(negedge HCLK);
    SS_N = 1'b1;
    repeat (8) @(negedge HCLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  mi;
    logic [31:0] d;

    vecs = '{
      '{4'h0, 1'b0, 32'h0000_0001},
      '{4'hC, 1'b1, 32'hFFFF_FFFF},
      '{4'hC, 1'b0, 32'h0000_0007},
      '{4'hC, 1'b1, 32'h0000_0000},
      '{4'hC, 1'b0, 32'h0000_0000},
      '{4'h8, 1'b0, 32'h0000_0000},
      '{4'h4, 1'b1, 32'h1234_56A5},
      '{4'h4, 1'b0, 32'h0000_00A5},
      '{4'h0, 1'b0, 32'h0000_0000},
      '{4'h8, 1'b1, 32'h0000_00FF},
      '{4'h0, 1'b0, 32'h0000_0000},
      '{4'h4, 1'b0, 32'h0000_00A5}
    };

    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
    HADDR = '0; HWDATA = '0; HTRANS = 2'b00;
    SCLK = 1'b0; MOSI = 1'b0; SS_N = 1'b1;
    repeat (3) @(negedge HCLK);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_miso_oe", {31'd0, MISO_OE}, 32'h0);
    check("rst_miso", {31'd0, MISO}, 32'h0);
    check("rst_irq", {31'd0, IRQ}, 32'h0);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) ahb_write({28'd0, vecs[i].addr}, vecs[i].data);
      else rd_check($sformatf("vec%0d_rd_%0h", i, vecs[i].addr), {28'd0, vecs[i].addr}, vecs[i].data);
    end

    // Single byte: TX holds 0xA5, master sends 0x3C
    frame_start();
    check("f1_miso_oe", {31'd0, MISO_OE}, 32'h1);
    spi_bits(8, 8'h3C, mi);
    check("f1_miso_byte", {24'd0, mi}, 32'hA5);
    repeat (8) @(negedge HCLK);
    rd_check("f1_status_active", 32'h0, 32'h0000_0153);
    SS_N = 1'b1;
    repeat (8) @(negedge HCLK);
    check("f1_miso_oe_off", {31'd0, MISO_OE}, 32'h0);
    rd_check("f1_status_idle", 32'h0, 32'h0000_0113);
    rd_check("f1_rxdata", 32'h8, 32'h0000_003C);
    rd_check("f1_status_popped", 32'h0, 32'h0000_0011);
    ahb_write(32'h0, 32'h10);
    rd_check("f1_status_w1c", 32'h0, 32'h0000_0001);

    // Five bytes into a depth-4 FIFO with no TX refill
    frame_start();
    for (int k = 1; k <= 5; k++) spi_bits(8, 8'(k), mi);
    check("ovf_miso_last", {24'd0, mi}, 32'h0);
    frame_end();
    rd_check("ovf_status", 32'h0, 32'h0000_041F);
    ahb_write(32'h0, 32'h18);
    rd_check("ovf_status_w1c", 32'h0, 32'h0000_0407);

    // Framing error after 3 SCLK cycles, with IE_ERR
    ahb_write(32'hC, 32'h4);
    ahb_write(32'h4, 32'h5A);
    @(negedge HCLK);
    check("ferr_irq_pre", {31'd0, IRQ}, 32'h0);
    frame_start();
    spi_bits(3, 8'hA0, mi);
    check("ferr_miso_bits", {24'd0, mi}, 32'h02);
    repeat (8) @(negedge HCLK);
    SS_N = 1'b1;
    repeat (3) @(negedge HCLK);
    check("ferr_irq_not_yet", {31'd0, IRQ}, 32'h0);
    @(negedge HCLK);
    check("ferr_irq_set", {31'd0, IRQ}, 32'h1);
    check("ferr_miso_oe", {31'd0, MISO_OE}, 32'h0);
    rd_check("ferr_status", 32'h0, 32'h0000_0427);
    ahb_write(32'h0, 32'h20);
    rd_check("ferr_status_w1c", 32'h0, 32'h0000_0407);
    check("ferr_irq_clr", {31'd0, IRQ}, 32'h0);

    // RXDATA pop in the very cycle the 8th-bit push hits a full FIFO
    ahb_write(32'hC, 32'h0);
    frame_start();
    spi_bits(7, 8'h77, mi);
    MOSI = 1'b1;
    repeat (8) @(negedge HCLK);
    SCLK = 1'b1;
    ahb_read(32'h8, d);
    check("coll_pop_data", d, 32'h01);
    repeat (6) @(negedge HCLK);
    SCLK = 1'b0;
    frame_end();
    rd_check("coll_status", 32'h0, 32'h0000_0417);
    rd_check("coll_rx1", 32'h8, 32'h02);
    rd_check("coll_rx2", 32'h8, 32'h03);
    rd_check("coll_rx3", 32'h8, 32'h04);
    rd_check("coll_rx4", 32'h8, 32'h77);
    rd_check("coll_status_empty", 32'h0, 32'h0000_0011);
    ahb_write(32'h0, 32'h10);

    // Reset in the middle of a frame (bitcnt=4)
    ahb_write(32'h4, 32'hC8);
    ahb_write(32'hC, 32'h2);
    frame_start();
    spi_bits(4, 8'h50, mi);
    repeat (4) @(negedge HCLK);
    check("mrst_miso_bits", {24'd0, mi}, 32'h0C);
    check("mrst_pre_miso", {31'd0, MISO}, 32'h1);
    check("mrst_pre_oe", {31'd0, MISO_OE}, 32'h1);
    check("mrst_pre_irq", {31'd0, IRQ}, 32'h1);
    #2 HRESET = 1'b1;
    #1;
    check("mrst_miso", {31'd0, MISO}, 32'h0);
    check("mrst_oe", {31'd0, MISO_OE}, 32'h0);
    check("mrst_irq", {31'd0, IRQ}, 32'h0);
    check("mrst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    SS_N = 1'b1;
    repeat (8) @(negedge HCLK);
    rd_check("mrst_status", 32'h0, 32'h0000_0001);
    ahb_write(32'h4, 32'h96);
    frame_start();
    spi_bits(8, 8'hE1, mi);
    check("mrst_f_miso", {24'd0, mi}, 32'h96);
    frame_end();
    rd_check("mrst_f_rxdata", 32'h8, 32'hE1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
